booth_multiplier_seq: RTL and testbench

- Iterative radix-4 Booth multiplier for the ALU MUL path.
- Parametrised successor to the combinational radix-2 multiplier: generic operand width, signed/unsigned mode, start/done handshake.
- Retires one radix-4 digit (2 multiplier bits) per clock, trading latency for area and timing.
- Sits between the ALU operand muxes and the HI/LO result registers; the control unit stalls on busy.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/booth_r4_encoder.sv | 21 ++
 rtl/booth_multiplier_seq.sv | 127 ++++++++++++
 tb/tb_booth_multiplier_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier FSM states, radix-4 Booth digit codes and
// the digit-count helper used by the sequential Booth multiplier.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mul_state_e;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_digit_e;

    // Radix-4 digits needed to cover a width-bit operand after 2-bit extension.
    function automatic int booth_iter(input int width);
        return (width + 2) / 2;
    endfunction

    function automatic booth_digit_e booth_decode(input logic [2:0] bits);
        booth_digit_e d;
        case (bits)
            3'b001, 3'b010: d = POS1;
            3'b011:         d = POS2;
            3'b100:         d = NEG2;
            3'b101, 3'b110: d = NEG1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: one overlapping multiplier triplet in, partial-product
// select bits out (negate, double, force-zero).
module booth_r4_encoder
    import alu_pkg::*;
(
    input  logic [2:0] bits_i,
    output logic       neg_o,
    output logic       two_o,
    output logic       zero_o
);

    booth_digit_e digit;

    always_comb begin
        digit  = booth_decode(bits_i);
        neg_o  = (digit == NEG1) || (digit == NEG2);
        two_o  = (digit == POS2) || (digit == NEG2);
        zero_o = (digit == ZERO);
    end

endmodule

// File: rtl/booth_multiplier_seq.sv
// Iterative radix-4 Booth multiplier, one digit per clock, start/done handshake.
// Define BOOTH_EARLY_TERM_EN to finish as soon as the remaining multiplier digits are all zero.
module booth_multiplier_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   PRODUCT
);

    localparam int ITER = booth_iter(WIDTH);
    localparam int CW   = $clog2(ITER + 1);
    localparam int AW   = 2 * WIDTH + 2;
    localparam int MW   = WIDTH + 3;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    mul_state_e           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [AW-1:0]        accum_q, accum_d;
    logic [AW-1:0]        mcand_q, mcand_d;
    logic [MW-1:0]        mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic                 a_sx, b_sx;
    logic [AW-1:0]        mcand_load;
    logic [MW-1:0]        mplier_load;
    logic                 dig_neg, dig_two, dig_zero;
    logic [AW-1:0]        pp_mag, addend, accum_step;
    logic [MW-1:0]        mplier_shift;
    logic                 last_iter;

    booth_r4_encoder u_enc (
        .bits_i (mplier_q[2:0]),
        .neg_o  (dig_neg),
        .two_o  (dig_two),
        .zero_o (dig_zero)
    );

    // Operand extension: sign bits only when is_signed, plus the Booth guard zero on B.
    always_comb begin
        a_sx        = is_signed & A[WIDTH-1];
        b_sx        = is_signed & B[WIDTH-1];
        mcand_load  = {{(WIDTH + 2){a_sx}}, A};
        mplier_load = {b_sx, b_sx, B, 1'b0};
    end

    always_comb begin
        pp_mag       = dig_two ? {mcand_q[AW-2:0], 1'b0} : mcand_q;
        addend       = dig_zero ? '0 : (dig_neg ? (~pp_mag + AW'(1)) : pp_mag);
        accum_step   = accum_q + addend;
        mplier_shift = {{2{mplier_q[MW-1]}}, mplier_q[MW-1:2]};
`ifdef BOOTH_EARLY_TERM_EN
        // Uniform remaining bits recode to 000/111 only, so no further digit contributes.
        last_iter    = (cnt_q == LAST) || (mplier_shift == '0) || (mplier_shift == '1);
`else
        last_iter    = (cnt_q == LAST);
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accum_d   = accum_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        product_d = product_q;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                done = (state_q == DONE);
                if (start) begin
                    accum_d  = '0;
                    mcand_d  = mcand_load;
                    mplier_d = mplier_load;
                    cnt_d    = '0;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                busy     = 1'b1;
                accum_d  = accum_step;
                mcand_d  = {mcand_q[AW-3:0], 2'b00};
                mplier_d = mplier_shift;
                cnt_d    = cnt_q + CW'(1);
                if (last_iter) begin
                    product_d = accum_step[2*WIDTH-1:0];
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Working registers are don't-care outside RUN, so they carry no reset.
    always_ff @(posedge clk) begin
        accum_q  <= accum_d;
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
    end

    assign PRODUCT = product_q;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Directed and table-driven bench for booth_multiplier_seq (WIDTH=32).
module tb_booth_multiplier_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy;
    logic        done;
    logic [63:0] PRODUCT;

    int n_pass = 0;
    int n_total = 0;

    booth_multiplier_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .PRODUCT   (PRODUCT)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp;
    } vec_t;

    vec_t vt[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb;
        logic [63:0] ua, ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'h0, a};
        ub = {32'h0, b};
        return ua * ub;
    endfunction

    // Cycles from the accepting edge until done is seen (1 = first cycle after that edge).
    function automatic int exp_lat(input logic [31:0] b, input logic s);
`ifdef BOOTH_EARLY_TERM_EN
        logic signed [34:0] e;
        logic signed [34:0] t;
        e = {s & b[31], s & b[31], b, 1'b0};
        for (int i = 0; i < 17; i++) begin
            t = e >>> (2 * i + 2);
            if (t == '0 || t == '1) return i + 2;
        end
        return 18;
`else
        if (s && b[31]) return 18;
        return 18;
`endif
    endfunction

    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        A = a; B = b; is_signed = s; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        int lat, bc, ndone, held_bad;
        logic [31:0] ra, rb;
        logic        rs;

        vt[0] = '{32'hFFFFFFF9, 32'h00000003, 1'b1, 64'hFFFFFFFFFFFFFFEB};
        vt[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
        vt[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001};
        vt[3] = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000};
        vt[4] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC000000080000000};
        vt[5] = '{32'h80000000, 32'h80000000, 1'b0, 64'h4000000000000000};
        vt[6] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 64'h3FFFFFFF00000001};
        vt[7] = '{32'h00000005, 32'h00000006, 1'b0, 64'h000000000000001E};
        vt[8] = '{32'h00000000, 32'h12345678, 1'b1, 64'h0000000000000000};
        vt[9] = '{32'h00000005, 32'h40000000, 1'b1, 64'h0000000140000000};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {63'h0, busy}, 64'h0);
        check("reset_done", {63'h0, done}, 64'h0);
        check("reset_product", PRODUCT, 64'h0);
        reset = 1'b0;

        // Table vectors
        for (int i = 0; i < 10; i++) begin
            launch(vt[i].a, vt[i].b, vt[i].s);
            wait_done(lat, bc);
            check($sformatf("vec%0d_product", i), PRODUCT, vt[i].exp);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat(vt[i].b, vt[i].s)));
            check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'(exp_lat(vt[i].b, vt[i].s) - 1));
        end

        // Back-to-back: second start issued in the DONE cycle
        launch(32'h10, 32'h10, 1'b0);
        wait_done(lat, bc);
        check("b2b_first_product", PRODUCT, 64'h100);
        A = 32'd5; B = 32'd6; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        held_bad = 0;
        lat = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
            if (PRODUCT !== 64'h100) held_bad++;
        end
        check("b2b_hold", 64'(held_bad), 64'h0);
        check("b2b_latency", 64'(lat), 64'(exp_lat(32'd6, 1'b0)));
        check("b2b_second_product", PRODUCT, 64'd30);

        // start pulsed mid-RUN must be ignored
        launch(32'd3, 32'h40000007, 1'b0);
        repeat (2) @(negedge clk);
        A = 32'd9; B = 32'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midrun_done_count", 64'(ndone), 64'd1);
        check("midrun_product", PRODUCT, 64'hC0000015);

        // Reset during RUN cycle 8
        launch(32'd5, 32'h40000000, 1'b1);
        repeat (7) @(negedge clk);
        check("pre_reset_busy", {63'h0, busy}, 64'h1);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_busy", {63'h0, busy}, 64'h0);
        check("midreset_done", {63'h0, done}, 64'h0);
        check("midreset_product", PRODUCT, 64'h0);
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("postreset_no_done", 64'(ndone), 64'd0);
        launch(32'hFFFFFFF7, 32'd9, 1'b1);
        wait_done(lat, bc);
        check("postreset_product", PRODUCT, 64'hFFFFFFFFFFFFFFAF);
        check("postreset_latency", 64'(lat), 64'(exp_lat(32'd9, 1'b1)));

        // Random vectors against the reference model
        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 0) rb = rb >> (i % 31);
            rs = 1'($urandom_range(0, 1));
            launch(ra, rb, rs);
            wait_done(lat, bc);
            check($sformatf("rand%0d_product", i), PRODUCT, ref_mul(ra, rb, rs));
            check($sformatf("rand%0d_latency", i), 64'(lat), 64'(exp_lat(rb, rs)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
